// File: rtl/friscv_pc_if.sv
// Fetch-stage next-PC bus: the control side selects the next-PC source
// and supplies an offset or target, and the PC register returns the
// current fetch address.
interface friscv_pc_if #(
    parameter int XLEN = 32
);
    logic [1:0]      pc_src_in;  // 00 seq, 01 pc-relative, 10 absolute, 11 hold
    logic [XLEN-1:0] imm_in;     // branch offset or absolute jump target
    logic [XLEN-1:0] pc_out;     // current program counter

    // Control / hazard unit side: it chooses the source and reads back the PC.
    modport master (
        output pc_src_in,
        output imm_in,
        input  pc_out
    );

    // Program-counter side.
    modport slave (
        input  pc_src_in,
        input  imm_in,
        output pc_out
    );
endinterface : friscv_pc_if

// File: rtl/friscv_pc.sv
// FRiscV fetch-stage program counter. The register holds the address of the
// instruction being fetched. On each rising edge it loads one of four
// sources: sequential, PC-relative, absolute (JALR), or hold. Every loaded
// value is forced to 4-byte alignment.
// rst_n is an asynchronous reset that is active-HIGH, despite its name.
module friscv_pc #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0   // must be 4-byte aligned
) (
    input  logic          clk,
    input  logic          rst_n,   // asserted = 1
    friscv_pc_if.slave    bus
);

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_REL  = 2'b01;
    localparam logic [1:0] SRC_ABS  = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    // Clears the two low address bits (RV32I, no compressed instructions).
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_sel;
    logic [XLEN-1:0] pc_d;

    // Next-PC source selection followed by alignment. All adds wrap modulo 2^XLEN.
    always_comb begin
        // NOTE: every combinational output gets a default first, so that no
        // path through the block can leave it unassigned and infer a latch.
        pc_sel = pc_q;
        case (bus.pc_src_in)
            SRC_SEQ:  pc_sel = pc_q + XLEN'(4);
            SRC_REL:  pc_sel = pc_q + bus.imm_in;
            SRC_ABS:  pc_sel = {bus.imm_in[XLEN-1:1], 1'b0};  // JALR clears bit 0
            SRC_HOLD: pc_sel = pc_q;
            // An unknown select propagates as X in simulation instead of
            // being silently treated as one of the valid sources.
            default:  pc_sel = 'x;
        endcase
        // Misaligned targets are truncated silently. No exception is raised.
        pc_d = pc_sel & ALIGN_MASK;
    end

    // PC register: asynchronous load of RESET_ADDR, otherwise the selected next PC.
    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples its inputs before any flop updates on the same edge.
        if (rst_n) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // The current PC drives the fetch address directly, with no extra stage.
    assign bus.pc_out = pc_q;

endmodule : friscv_pc

// File: tb/tb_friscv_pc.sv
// Self-checking bench for friscv_pc. It runs directed cases for reset,
// sequential, relative, absolute/alignment, hold/wrap and asynchronous
// reset. It then runs a randomized phase checked against a behavioural
// next-PC model.
module tb_friscv_pc;

    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic clk;
    logic rst_n;   // active-high asynchronous reset

    friscv_pc_if #(.XLEN(XLEN)) bus ();

    friscv_pc #(
        .XLEN       (XLEN),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_pc;

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural next-PC rule: pick the raw target, then round it down to a
    // multiple of four. That single rounding covers both the JALR bit-0 rule
    // and the bit-1 alignment rule.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic [31:0] imm);
        logic [31:0] target;
        case (sel)
            2'd0:    target = pc + 32'd4;
            2'd1:    target = pc + imm;
            2'd2:    target = imm;
            default: target = pc;
        endcase
        return target - (target % 32'd4);
    endfunction

    // The task is called at a negedge. It drives the inputs, takes one rising
    // edge, updates the model and returns at the next negedge.
    task automatic drive_edge(input logic [1:0] sel, input logic [31:0] imm);
        bus.pc_src_in = sel;
        bus.imm_in    = imm;
        @(posedge clk);
        #1;
        if (rst_n) model_pc = RESET_ADDR;
        else       model_pc = next_pc(model_pc, sel, imm);
        @(negedge clk);
    endtask

    // While reset is asserted, the PC must read RESET_ADDR after every rising edge.
    always begin
        @(posedge clk);
        if (rst_n) begin
            #1;
            check("reset_hold", bus.pc_out, RESET_ADDR);
        end
    end

    // This guard ends the run if anything stalls.
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.pc_src_in = 2'b00;
        bus.imm_in    = '0;
        model_pc      = RESET_ADDR;

        // 1. Reset held for two clocks while the inputs vary randomly.
        #1 rst_n = 1'b1;
        #1 check("reset_async_initial", bus.pc_out, RESET_ADDR);
        repeat (2) begin
            bus.pc_src_in = 2'($urandom_range(0, 3));
            bus.imm_in    = $urandom;
            @(posedge clk);
            #1;
            check("reset_inputs_ignored", bus.pc_out, RESET_ADDR);
            @(negedge clk);
        end

        // 2. Sequential stepping after reset is released.
        rst_n = 1'b0;
        model_pc = RESET_ADDR;
        #1 check("release_no_edge", bus.pc_out, 32'h0);
        drive_edge(2'b00, $urandom); check("seq_1", bus.pc_out, 32'h4);
        drive_edge(2'b00, $urandom); check("seq_2", bus.pc_out, 32'h8);
        drive_edge(2'b00, $urandom); check("seq_3", bus.pc_out, 32'hC);
        drive_edge(2'b00, $urandom); check("seq_4", bus.pc_out, 32'h10);

        // 3. PC-relative, with a negative and then a positive offset.
        drive_edge(2'b01, 32'hFFFF_FFF8); check("rel_neg", bus.pc_out, 32'h08);
        drive_edge(2'b01, 32'h0000_0100); check("rel_pos", bus.pc_out, 32'h108);

        // 4. Absolute target with low bits set, and a misaligned relative offset.
        drive_edge(2'b10, 32'h0000_1003); check("abs_align", bus.pc_out, 32'h1000);
        drive_edge(2'b10, 32'h0000_0000); check("abs_zero", bus.pc_out, 32'h0);
        drive_edge(2'b01, 32'h0000_0006); check("rel_misalign", bus.pc_out, 32'h4);

        // 5. Hold at the top of the address space, then wrap to zero.
        drive_edge(2'b10, 32'hFFFF_FFFC); check("abs_top", bus.pc_out, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            drive_edge(2'b11, $urandom);
            check("hold", bus.pc_out, 32'hFFFF_FFFC);
        end
        drive_edge(2'b00, 32'h0); check("seq_wrap", bus.pc_out, 32'h0);
        drive_edge(2'b01, 32'hFFFF_FFF0); check("rel_wrap_neg", bus.pc_out, 32'hFFFF_FFF0);

        // 6. Asynchronous reset asserted between edges while a stall is pending.
        drive_edge(2'b10, 32'h0000_0200); check("abs_200", bus.pc_out, 32'h200);
        bus.pc_src_in = 2'b11;
        #2 rst_n = 1'b1;
        #1 check("reset_async_midrun", bus.pc_out, RESET_ADDR);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_pc = RESET_ADDR;
        drive_edge(2'b00, 32'h0); check("seq_after_reset", bus.pc_out, 32'h4);

        // Randomized phase checked against the model, with occasional
        // asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                bus.pc_src_in = 2'($urandom_range(0, 3));
                bus.imm_in    = $urandom;
                #2 rst_n = 1'b1;
                #1 check("rand_async_reset", bus.pc_out, RESET_ADDR);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b0;
                model_pc = RESET_ADDR;
            end else begin
                logic [1:0]  sel;
                logic [31:0] imm;
                sel = 2'($urandom_range(0, 3));
                // Bias toward small offsets so that relative jumps stay varied.
                imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
                drive_edge(sel, imm);
                check("rand_model", bus.pc_out, model_pc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_friscv_pc
